// File: rtl/dmac_fifo_dp_if.sv
// dmac_fifo_dp_if: bus between the DMAC FIFO next-state logic / DMAC engine
// (master) and the FIFO sequential datapath (slave).
//   next_state : 3-bit state code for the coming cycle (master -> slave)
//   din        : write data (master -> slave)
//   state      : registered current state (slave -> master)
//   data_count : occupancy 0..8 (slave -> master)
//   dout       : registered read data (slave -> master)
//   full/empty : occupancy flags (slave -> master)
//   wr_ack/wr_err/rd_ack/rd_err : registered handshake flags (slave -> master)
interface dmac_fifo_dp_if #(
   parameter int DATA_WIDTH = 32
);
   logic [2:0]            next_state;
   logic [DATA_WIDTH-1:0] din;
   logic [2:0]            state;
   logic [3:0]            data_count;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;

   modport master (
      output next_state, din,
      input  state, data_count, dout, full, empty,
      input  wr_ack, wr_err, rd_ack, rd_err
   );

   modport slave (
      input  next_state, din,
      output state, data_count, dout, full, empty,
      output wr_ack, wr_err, rd_ack, rd_err
   );
endinterface

// File: rtl/dmac_fifo_dp.sv
// dmac_fifo_dp: sequential datapath of the DMAC FIFO. Holds the state
// register, an 8 x DATA_WIDTH storage array, head/tail pointers and the
// occupancy counter, and performs the write/read/error action selected by
// the incoming next_state code each clock.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmac_fifo_dp_if slave modport (next_state/din in; state,
//           data_count, dout, full, empty and handshake flags out)
module dmac_fifo_dp #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic           clk,
   input  logic           reset,
   dmac_fifo_dp_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_WRITE    = 3'b001,
      ST_READ     = 3'b010,
      ST_WR_ERROR = 3'b011,
      ST_RD_ERROR = 3'b100
   } state_e;

   localparam logic [3:0] COUNT_FULL = 4'(DEPTH);

   state_e                state_q, state_d;
   logic [2:0]            head_q, head_d;
   logic [2:0]            tail_q, tail_d;
   logic [3:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  wr_err_q, wr_err_d;
   logic                  rd_ack_q, rd_ack_d;
   logic                  rd_err_q, rd_err_d;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q [8];

   always_comb begin
      state_d  = ST_IDLE;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      dout_d   = dout_q;
      wr_ack_d = 1'b0;
      wr_err_d = 1'b0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
      mem_we   = 1'b0;
      // Codes 101..111 fall to the default: load IDLE, no action.
      case (bus.next_state)
         ST_WRITE: begin
            state_d = ST_WRITE;
            if (count_q != COUNT_FULL) begin
               mem_we   = 1'b1;
               tail_d   = tail_q + 3'd1;
               count_d  = count_q + 4'd1;
               wr_ack_d = 1'b1;
            end else begin
               wr_err_d = 1'b1;
            end
         end
         ST_READ: begin
            state_d = ST_READ;
            if (count_q != 4'd0) begin
               dout_d   = mem_q[head_q];
               head_d   = head_q + 3'd1;
               count_d  = count_q - 4'd1;
               rd_ack_d = 1'b1;
            end else begin
               rd_err_d = 1'b1;
            end
         end
         ST_WR_ERROR: begin
            state_d  = ST_WR_ERROR;
            wr_err_d = 1'b1;
         end
         ST_RD_ERROR: begin
            state_d  = ST_RD_ERROR;
            rd_err_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
      end
   end

   // Storage is not reset; stale contents are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[tail_q] <= bus.din;
   end

   assign bus.state      = state_q;
   assign bus.data_count = count_q;
   assign bus.dout       = dout_q;
   assign bus.full       = (count_q == COUNT_FULL);
   assign bus.empty      = (count_q == 4'd0);
   assign bus.wr_ack     = wr_ack_q;
   assign bus.wr_err     = wr_err_q;
   assign bus.rd_ack     = rd_ack_q;
   assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_dmac_fifo_dp.sv
// tb_dmac_fifo_dp: directed bench for dmac_fifo_dp.
module tb_dmac_fifo_dp;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   dmac_fifo_dp_if #(.DATA_WIDTH(32)) bus ();

   dmac_fifo_dp #(.DATA_WIDTH(32), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a code at the falling edge, then settle just past the rising edge.
   task automatic step(input logic [2:0] ns, input logic [31:0] d);
      @(negedge clk);
      bus.next_state = ns;
      bus.din        = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] flags();
      return {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
   endfunction

   task automatic test_power_on;
      reset = 1'b0;
      bus.next_state = 3'b000;
      bus.din = '0;
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.state !== 3'b000 || bus.data_count !== 4'd0 || bus.dout !== 32'h0) begin
         n_fail++;
         $display("FAIL por_regs: state=%b count=%0d dout=%h expected 000/0/0", bus.state, bus.data_count, bus.dout);
      end
      n_checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0 || flags() !== 4'b0000) begin
         n_fail++;
         $display("FAIL por_flags: empty=%b full=%b flags=%b expected 1/0/0000", bus.empty, bus.full, flags());
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_fill;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 32'((i + 1) * 32'h11);
         step(3'b001, d);
         n_checks++;
         if (bus.data_count !== 4'(i + 1) || flags() !== 4'b1000 || bus.state !== 3'b001) begin
            n_fail++;
            $display("FAIL fill_%0d: count=%0d flags=%b state=%b expected %0d/1000/001", i, bus.data_count, flags(), bus.state, i + 1);
         end
         n_checks++;
         if (bus.full !== (i == 7) || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full_%0d: full=%b empty=%b expected %b/0", i, bus.full, bus.empty, (i == 7));
         end
      end
      step(3'b001, 32'hDEAD_BEEF);
      n_checks++;
      if (bus.data_count !== 4'd8 || flags() !== 4'b0100 || bus.state !== 3'b001 || bus.full !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_overflow: count=%0d flags=%b state=%b full=%b expected 8/0100/001/1", bus.data_count, flags(), bus.state, bus.full);
      end
   endtask

   task automatic test_drain;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 32'((i + 1) * 32'h11);
         step(3'b010, 32'h0);
         n_checks++;
         if (bus.dout !== d || flags() !== 4'b0010 || bus.data_count !== 4'(7 - i)) begin
            n_fail++;
            $display("FAIL drain_%0d: dout=%h flags=%b count=%0d expected %h/0010/%0d", i, bus.dout, flags(), bus.data_count, d, 7 - i);
         end
      end
      step(3'b010, 32'h0);
      n_checks++;
      if (bus.dout !== 32'h88 || flags() !== 4'b0001 || bus.empty !== 1'b1 || bus.data_count !== 4'd0) begin
         n_fail++;
         $display("FAIL drain_underflow: dout=%h flags=%b empty=%b count=%0d expected 88/0001/1/0", bus.dout, flags(), bus.empty, bus.data_count);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] d;
      for (int i = 0; i < 6; i++) step(3'b001, 32'h100 + 32'(i));
      for (int i = 0; i < 6; i++) step(3'b010, 32'h0);
      n_checks++;
      if (bus.dout !== 32'h105 || bus.data_count !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_pre: dout=%h count=%0d expected 105/0", bus.dout, bus.data_count);
      end
      for (int i = 0; i < 5; i++) step(3'b001, 32'hA1 + 32'(i));
      n_checks++;
      if (bus.data_count !== 4'd5) begin
         n_fail++;
         $display("FAIL wrap_count: count=%0d expected 5", bus.data_count);
      end
      for (int i = 0; i < 5; i++) begin
         d = 32'hA1 + 32'(i);
         step(3'b010, 32'h0);
         n_checks++;
         if (bus.dout !== d || flags() !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_rd_%0d: dout=%h flags=%b expected %h/0010", i, bus.dout, flags(), d);
         end
      end
      n_checks++;
      if (bus.data_count !== 4'd0 || bus.empty !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_end: count=%0d empty=%b expected 0/1", bus.data_count, bus.empty);
      end
   endtask

   task automatic test_error_idle;
      for (int i = 0; i < 3; i++) step(3'b001, 32'hB1 + 32'(i));
      step(3'b011, 32'hFFFF_FFFF);
      n_checks++;
      if (flags() !== 4'b0100 || bus.data_count !== 4'd3 || bus.dout !== 32'hA5 || bus.state !== 3'b011) begin
         n_fail++;
         $display("FAIL wr_error: flags=%b count=%0d dout=%h state=%b expected 0100/3/a5/011", flags(), bus.data_count, bus.dout, bus.state);
      end
      step(3'b100, 32'h0);
      n_checks++;
      if (flags() !== 4'b0001 || bus.data_count !== 4'd3 || bus.dout !== 32'hA5 || bus.state !== 3'b100) begin
         n_fail++;
         $display("FAIL rd_error: flags=%b count=%0d dout=%h state=%b expected 0001/3/a5/100", flags(), bus.data_count, bus.dout, bus.state);
      end
      step(3'b000, 32'h0);
      n_checks++;
      if (flags() !== 4'b0000 || bus.data_count !== 4'd3 || bus.state !== 3'b000) begin
         n_fail++;
         $display("FAIL idle: flags=%b count=%0d state=%b expected 0000/3/000", flags(), bus.data_count, bus.state);
      end
   endtask

   task automatic test_illegal;
      step(3'b010, 32'h0);
      n_checks++;
      if (bus.dout !== 32'hB1 || bus.data_count !== 4'd2) begin
         n_fail++;
         $display("FAIL illegal_setup: dout=%h count=%0d expected b1/2", bus.dout, bus.data_count);
      end
      step(3'b110, 32'h0);
      n_checks++;
      if (bus.state !== 3'b000 || flags() !== 4'b0000 || bus.data_count !== 4'd2 || bus.dout !== 32'hB1) begin
         n_fail++;
         $display("FAIL illegal_code: state=%b flags=%b count=%0d dout=%h expected 000/0000/2/b1", bus.state, flags(), bus.data_count, bus.dout);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) step(3'b001, 32'hC1 + 32'(i));
      n_checks++;
      if (bus.data_count !== 4'd5 || bus.wr_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_setup: count=%0d wr_ack=%b expected 5/1", bus.data_count, bus.wr_ack);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.state !== 3'b000 || bus.data_count !== 4'd0 || bus.dout !== 32'h0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || flags() !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_async: state=%b count=%0d dout=%h empty=%b full=%b flags=%b expected 000/0/0/1/0/0000", bus.state, bus.data_count, bus.dout, bus.empty, bus.full, flags());
      end
      @(negedge clk);
      reset = 1'b0;
      bus.next_state = 3'b001;
      bus.din = 32'h77;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.state !== 3'b001 || bus.data_count !== 4'd1 || flags() !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_release: state=%b count=%0d flags=%b expected 001/1/1000", bus.state, bus.data_count, flags());
      end
      step(3'b010, 32'h0);
      n_checks++;
      if (bus.dout !== 32'h77 || bus.data_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_discard: dout=%h count=%0d expected 77/0", bus.dout, bus.data_count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_power_on();
      test_fill();
      test_drain();
      test_wrap();
      test_error_idle();
      test_illegal();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmac_fifo_dp.md
# dmac_fifo_dp

Sequential datapath of the DMAC FIFO: holds the FIFO state register, an 8-entry × 32-bit storage array, head/tail pointers and the occupancy counter. Each clock it consumes the `next_state` code produced by the FIFO next-state logic and performs the corresponding write, read or error action. It returns `state` and `data_count` to that logic, closing the loop, and supplies `dout` plus the handshake flags to the DMAC engine.

## Interface
- DATA_WIDTH, 32: width of `din`/`dout` and of each storage entry.
- DEPTH, 8: number of entries. Fixed; pointers are 3 bits and `data_count` is 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- next_state  input  3  state code for the coming cycle: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100.
- din  input  DATA_WIDTH  write data, sampled on the edge where `next_state`==WRITE.
- state  output  3  registered current state.
- data_count  output  4  occupancy, 0..8.
- dout  output  DATA_WIDTH  registered read data.
- full  output  1  `data_count`==8 (combinational from the count register).
- empty  output  1  `data_count`==0 (combinational from the count register).
- wr_ack  output  1  registered; 1 for the cycle following a completed write.
- wr_err  output  1  registered; 1 for the cycle following a rejected write.
- rd_ack  output  1  registered; 1 for the cycle following a completed read.
- rd_err  output  1  registered; 1 for the cycle following a rejected read.

## Operation
- Reset (asynchronous, active-high) drives these values immediately, independent of `clk`:
  - `state`=IDLE; head=0, tail=0; `data_count`=0; `dout`=0.
  - All four handshake flags = 0; `empty`=1, `full`=0.
  - Storage contents are don't-care.
- Every rising edge out of reset, `state` <= `next_state`. Codes 101–111 are illegal: they load IDLE and perform no action.
- Action is selected by `next_state` at the edge.
  - **IDLE:** no change to storage, pointers, count or `dout`.
  - **WRITE with `data_count`<8:** mem[tail]<=`din`; tail<=tail+1; `data_count`+1; `wr_ack`<=1.
  - **WRITE with `data_count`==8 (guard against an illegal request):**
    - Storage, pointers and count are unchanged; `wr_err`<=1.
    - `state` still loads WRITE.
  - **READ with `data_count`>0:** `dout`<=mem[head]; head<=head+1; `data_count`−1; `rd_ack`<=1.
  - **READ with `data_count`==0 (guard):** no change; `rd_err`<=1.
  - **WR_ERROR:** no storage change; `wr_err`<=1.
  - **RD_ERROR:** no storage change; `rd_err`<=1.
- Each handshake flag is 0 on any edge where its condition does not hold.
- At most one of the four flags is 1 in any cycle.
- `dout` holds its last read value until the next successful read. Error states and writes never alter it.
- Pointers are 3-bit and wrap modulo 8 (7→0) with no special handling.
- `data_count` never leaves 0..8. It is not derived from the pointers; head==tail is ambiguous between empty and full.
- FIFO order is strict: reads return data in write order across wrap.

## Timing
- Write latency:
  - Data is stored on the edge where `next_state`==WRITE.
  - `data_count`, `full`/`empty` and `wr_ack` reflect it in the cycle after that edge.
- Read latency: `dout` is valid in the cycle after the edge where `next_state`==READ, coincident with `rd_ack`=1.
- Back-to-back: one write or one read per cycle. Consecutive WRITE cycles fill 8 entries in 8 edges.
- Simultaneous read and write cannot occur, because `next_state` is a single code.
- The `state`/`data_count` → next-state → `next_state` loop is purely combinational outside this block. All outputs here except `full`/`empty` are registers.
- Reset asserted mid-burst:
  - Outputs clear immediately, and pending data is discarded.
  - The first edge after deassertion loads `next_state` normally.

## Test plan
- **Reset:** assert `reset` mid-cycle with `data_count`=5 → `state`=000, `data_count`=0, `dout`=0, `empty`=1, all flags 0 before the next `clk` edge.
- **Fill:** 8 consecutive WRITE cycles with `din`=0x11..0x88 → `data_count` steps 1..8, `wr_ack`=1 each following cycle, `full`=1 after the 8th. A 9th WRITE request → `wr_err`=1 and `data_count` stays 8.
- **Drain in order:** 8 READ cycles from full → `dout`=0x11,0x22,…,0x88 with `rd_ack`=1. A 9th READ → `rd_err`=1, `dout` holds 0x88, `empty`=1.
- **Wrap-around:**
  - Write 6, read 6, write 5 (0xA1..0xA5), read 5.
  - Required: reads return 0xA1..0xA5 in order, tail passes 7→0, and `data_count` ends at 0.
- **Error/idle states:** `next_state`=011 with `data_count`=3 → `wr_err`=1, count and `dout` unchanged. `next_state`=100 → `rd_err`=1. `next_state`=000 → all flags 0.
- **Illegal code:** `next_state`=110 with `data_count`=2 → `state` loads 000, no flags, `data_count`=2.
